// File: rtl/preadd_mac_pipe_pkg.sv
// -----------------------------------------------------------------------------
// preadd_mac_pkg
// Shared constants and helpers for the pre-add / multiply / accumulate
// pipeline:
//   - clog2 / max2 constant functions
//   - width derivation for the pre-adder, lane product and lane sum
//   - saturation bounds for a W_OUT-bit signed result
//   - mode_t: per-sample mode bits carried alongside the data
// -----------------------------------------------------------------------------
package preadd_mac_pkg;

   typedef struct packed {
      logic rnd;   // round half up instead of floor
      logic sat;   // clamp instead of wrap on overflow
   } mode_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   // One extra bit so the pre-add can never overflow.
   function automatic int calc_w_pre(input int w_a, input int w_b, input int shift_b);
      return max2(w_a, w_b + shift_b) + 1;
   endfunction

   function automatic int calc_w_p(input int w_pre, input int w_c);
      return w_pre + w_c;
   endfunction

   // Growth of clog2(lanes) bits keeps the lane sum lossless.
   function automatic int calc_w_sum(input int w_p, input int lanes);
      return w_p + clog2(lanes);
   endfunction

   // Largest / smallest W_OUT-bit signed value, returned in 64 bits;
   // callers keep the low W_OUT bits.
   function automatic logic [63:0] sat_max(input int w_out);
      return (64'd1 << (w_out - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w_out);
      return ~sat_max(w_out);
   endfunction

endpackage

// File: rtl/preadd_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// preadd_mac_pipe_if
// Sample/control bus of the pre-add MAC pipeline.
//   master: drives ce, in_valid, a, b, c, rnd_en, sat_en, clr
//           and observes y, out_valid, out_ovf, ovf_sticky
//   slave : the pipeline itself (opposite directions)
// a/b/c pack lane i at [i*W +: W], each lane signed.
// -----------------------------------------------------------------------------
interface preadd_mac_pipe_if #(
   parameter int LANES = 2,
   parameter int W_A   = 18,
   parameter int W_B   = 8,
   parameter int W_C   = 12,
   parameter int W_OUT = 36
);
   logic                     ce;
   logic                     in_valid;
   logic [LANES*W_A-1:0]     a;
   logic [LANES*W_B-1:0]     b;
   logic [LANES*W_C-1:0]     c;
   logic                     rnd_en;
   logic                     sat_en;
   logic                     clr;
   logic signed [W_OUT-1:0]  y;
   logic                     out_valid;
   logic                     out_ovf;
   logic                     ovf_sticky;

   modport master (
      output ce, in_valid, a, b, c, rnd_en, sat_en, clr,
      input  y, out_valid, out_ovf, ovf_sticky
   );

   modport slave (
      input  ce, in_valid, a, b, c, rnd_en, sat_en, clr,
      output y, out_valid, out_ovf, ovf_sticky
   );
endinterface

// File: rtl/preadd_mult_lane.sv
// -----------------------------------------------------------------------------
// preadd_mult_lane
// One product lane, stages 1-3: p = (a + (b <<< SHIFT_B)) * c.
//   clk, rst_n : clock, asynchronous active-low reset
//   ce         : clock enable, all registers hold when low
//   a_i/b_i/c_i: signed lane operands
//   p_o        : signed lane product, three registered stages after a_i
// -----------------------------------------------------------------------------
module preadd_mult_lane
   import preadd_mac_pkg::*;
#(
   parameter  int W_A     = 18,
   parameter  int W_B     = 8,
   parameter  int SHIFT_B = 5,
   parameter  int W_C     = 12,
   localparam int W_PRE   = calc_w_pre(W_A, W_B, SHIFT_B),
   localparam int W_P     = calc_w_p(W_PRE, W_C)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic signed [W_A-1:0] a_i,
   input  logic signed [W_B-1:0] b_i,
   input  logic signed [W_C-1:0] c_i,
   output logic signed [W_P-1:0] p_o
);
   logic signed [W_PRE-1:0] pre_d, pre_q;
   logic signed [W_C-1:0]   c_q;
   logic signed [W_P-1:0]   prod_q, p_q;

   // Both operands sign-extended to W_PRE before shifting/adding.
   assign pre_d = W_PRE'(a_i) + (W_PRE'(b_i) <<< SHIFT_B);

   // c is registered next to pre so both reach the multiplier together;
   // the product gets an extra output register for DSP pipelining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         c_q    <= '0;
         prod_q <= '0;
         p_q    <= '0;
      end else if (ce) begin
         pre_q  <= pre_d;
         c_q    <= c_i;
         prod_q <= W_P'(pre_q) * W_P'(c_q);
         p_q    <= prod_q;
      end
   end

   assign p_o = p_q;
endmodule

// File: rtl/preadd_mac_pipe.sv
// -----------------------------------------------------------------------------
// preadd_mac_pipe
// Five-stage pipelined Y = sum_i (A_i + (B_i <<< SHIFT_B)) * C_i with output
// shift, optional round-half-up and optional saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): ce, in_valid, a, b, c, rnd_en, sat_en, clr in;
//                y, out_valid, out_ovf, ovf_sticky out
// Stages: 1-3 per lane (preadd_mult_lane), 4 lane sum, 5 scale/round/sat.
// -----------------------------------------------------------------------------
module preadd_mac_pipe
   import preadd_mac_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int W_A       = 18,
   parameter int W_B       = 8,
   parameter int SHIFT_B   = 5,
   parameter int W_C       = 12,
   parameter int OUT_SHIFT = 0,
   parameter int W_OUT     = 36
) (
   input  logic             clk,
   input  logic             rst_n,
   preadd_mac_pipe_if.slave bus
);
   localparam int W_PRE = calc_w_pre(W_A, W_B, SHIFT_B);
   localparam int W_P   = calc_w_p(W_PRE, W_C);
   localparam int W_SUM = calc_w_sum(W_P, LANES);
   localparam int W_T   = W_SUM + 1;
   // Working width for the range check: never narrower than the output.
   localparam int W_E   = max2(W_T, W_OUT);
   localparam logic signed [W_T-1:0]   RND_K = W_T'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0);
   localparam logic signed [W_OUT-1:0] Y_MAX = W_OUT'(sat_max(W_OUT));
   localparam logic signed [W_OUT-1:0] Y_MIN = W_OUT'(sat_min(W_OUT));

   // ---------------- stages 1-3: lanes ----------------
   logic signed [W_P-1:0] p_lane [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      preadd_mult_lane #(
         .W_A     (W_A),
         .W_B     (W_B),
         .SHIFT_B (SHIFT_B),
         .W_C     (W_C)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ce    (bus.ce),
         .a_i   (bus.a[gi*W_A +: W_A]),
         .b_i   (bus.b[gi*W_B +: W_B]),
         .c_i   (bus.c[gi*W_C +: W_C]),
         .p_o   (p_lane[gi])
      );
   end

   // ---------------- sideband ----------------
   // Valid runs the full depth; mode bits are consumed by stage 5, which
   // works on the output of register level 4.
   logic [4:0] vld_q;
   mode_t      mode_q [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < 4; i++) mode_q[i] <= '0;
      end else if (bus.ce) begin
         vld_q     <= {vld_q[3:0], bus.in_valid};
         mode_q[0] <= '{rnd: bus.rnd_en, sat: bus.sat_en};
         for (int i = 1; i < 4; i++) mode_q[i] <= mode_q[i-1];
      end
   end

   // ---------------- stage 4: lane sum ----------------
   logic signed [W_SUM-1:0] sum_d, sum_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) sum_d = sum_d + W_SUM'(p_lane[i]);
   end

   // ---------------- stage 5: round, shift, range ----------------
   logic signed [W_T-1:0]     rnd_add, t_rnd, t;
   logic signed [W_E-1:0]     t_e;
   logic [W_E-W_OUT:0]        hi;
   logic                      ovf_d;
   logic signed [W_OUT-1:0]   y_d;

   assign rnd_add = (mode_q[3].rnd && (OUT_SHIFT > 0)) ? RND_K : '0;
   assign t_rnd   = W_T'(sum_q) + rnd_add;
   assign t       = t_rnd >>> OUT_SHIFT;
   assign t_e     = W_E'(t);
   // t fits W_OUT exactly when every bit from the output sign bit upward
   // agrees with it.
   assign hi      = t_e[W_E-1:W_OUT-1];
   assign ovf_d   = !((&hi) || !(|hi));

   always_comb begin
      y_d = t_e[W_OUT-1:0];
      if (ovf_d && mode_q[3].sat) y_d = t_e[W_E-1] ? Y_MIN : Y_MAX;
   end

   logic signed [W_OUT-1:0] y_q;
   logic                    ovf_q;
   logic                    sticky_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         y_q   <= '0;
         ovf_q <= 1'b0;
      end else if (bus.ce) begin
         sum_q <= sum_d;
         y_q   <= y_d;
         ovf_q <= vld_q[3] && ovf_d;   // qualified by the sample's valid
      end
   end

   // Sticky runs off the displayed outputs and ignores ce; set beats clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 1'b0;
      else        sticky_q <= (vld_q[4] && ovf_q) || (sticky_q && !bus.clr);
   end

   assign bus.y          = y_q;
   assign bus.out_valid  = vld_q[4];
   assign bus.out_ovf    = ovf_q;
   assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_preadd_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_preadd_mac_pipe
// Three pipelines share one stimulus: defaults (dut0), OUT_SHIFT=4 (dut1)
// and W_OUT=16 (dut2). A per-sample arithmetic model predicts each output
// and is delayed by five enabled cycles; table vectors and hand sequences
// add fixed expectations for the documented corner cases.
// -----------------------------------------------------------------------------
module tb_preadd_mac_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        ce, in_valid, rnd_en, sat_en, clr;
   logic [35:0] a;
   logic [15:0] b;
   logic [23:0] c;

   preadd_mac_pipe_if #(.W_OUT(36)) bus0 ();
   preadd_mac_pipe_if #(.W_OUT(36)) bus1 ();
   preadd_mac_pipe_if #(.W_OUT(16)) bus2 ();

   assign bus0.ce = ce; assign bus0.in_valid = in_valid; assign bus0.rnd_en = rnd_en;
   assign bus0.sat_en = sat_en; assign bus0.clr = clr;
   assign bus0.a = a; assign bus0.b = b; assign bus0.c = c;
   assign bus1.ce = ce; assign bus1.in_valid = in_valid; assign bus1.rnd_en = rnd_en;
   assign bus1.sat_en = sat_en; assign bus1.clr = clr;
   assign bus1.a = a; assign bus1.b = b; assign bus1.c = c;
   assign bus2.ce = ce; assign bus2.in_valid = in_valid; assign bus2.rnd_en = rnd_en;
   assign bus2.sat_en = sat_en; assign bus2.clr = clr;
   assign bus2.a = a; assign bus2.b = b; assign bus2.c = c;

   preadd_mac_pipe u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   preadd_mac_pipe #(.OUT_SHIFT(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   preadd_mac_pipe #(.W_OUT(16))    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   longint y_obs [3];
   bit     v_obs [3];
   bit     o_obs [3];
   bit     s_obs [3];

   always_comb begin
      y_obs[0] = longint'(bus0.y); v_obs[0] = bus0.out_valid;
      o_obs[0] = bus0.out_ovf;     s_obs[0] = bus0.ovf_sticky;
      y_obs[1] = longint'(bus1.y); v_obs[1] = bus1.out_valid;
      o_obs[1] = bus1.out_ovf;     s_obs[1] = bus1.ovf_sticky;
      y_obs[2] = longint'(bus2.y); v_obs[2] = bus2.out_valid;
      o_obs[2] = bus2.out_ovf;     s_obs[2] = bus2.ovf_sticky;
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit     vld;
      longint y;
      bit     ovf;
   } exp_t;

   exp_t pipe [3][5];
   bit   sticky_m [3];
   int   osh [3] = '{0, 4, 0};
   int   wo  [3] = '{36, 36, 16};
   int   tests = 0;
   int   fails = 0;

   function automatic void ref_calc(input int k, input logic [35:0] av, input logic [15:0] bv,
                                    input logic [23:0] cv, input bit rnd, input bit sat,
                                    output longint y, output bit ovf);
      longint s, t, mx, mn, ai, bi, ci;
      s = 0;
      for (int i = 0; i < 2; i++) begin
         ai = longint'($signed(av[i*18 +: 18]));
         bi = longint'($signed(bv[i*8 +: 8]));
         ci = longint'($signed(cv[i*12 +: 12]));
         s  = s + (ai + bi * 32) * ci;
      end
      t = s;
      if (rnd && osh[k] > 0) t = t + (64'sd1 <<< (osh[k] - 1));
      t  = t >>> osh[k];
      mx = (64'sd1 <<< (wo[k] - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      ovf = (t > mx) || (t < mn);
      if (!ovf)     y = t;
      else if (sat) y = (t > mx) ? mx : mn;
      else          y = (t <<< (64 - wo[k])) >>> (64 - wo[k]);
   endfunction

   function automatic void reset_model();
      for (int k = 0; k < 3; k++) begin
         sticky_m[k] = 1'b0;
         for (int j = 0; j < 5; j++) pipe[k][j] = '{0, 0, 0};
      end
   endfunction

   function automatic void chk(input string nm, input int k, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
      end
   endfunction

   function automatic void check_outputs();
      for (int k = 0; k < 3; k++) begin
         chk("out_valid", k, longint'(v_obs[k]), longint'(pipe[k][4].vld));
         chk("out_ovf", k, longint'(o_obs[k]), longint'(pipe[k][4].ovf));
         chk("ovf_sticky", k, longint'(s_obs[k]), longint'(sticky_m[k]));
         if (pipe[k][4].vld) chk("y", k, y_obs[k], pipe[k][4].y);
      end
   endfunction

   // One clock: the model sees the inputs present at the edge, outputs are
   // compared 1 time unit after it.
   task automatic tick();
      longint yv;
      bit     ov;
      bit     nst;
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            nst = (pipe[k][4].vld && pipe[k][4].ovf) || (sticky_m[k] && !clr);
            if (ce) begin
               for (int j = 4; j > 0; j--) pipe[k][j] = pipe[k][j-1];
               ref_calc(k, a, b, c, rnd_en, sat_en, yv, ov);
               pipe[k][0] = '{in_valid, yv, in_valid && ov};
            end
            sticky_m[k] = nst;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic rand_inputs();
      a = {4'($urandom), 32'($urandom)};
      b = 16'($urandom);
      c = 24'($urandom);
      rnd_en = 1'($urandom);
      sat_en = 1'($urandom);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int     dut;
      int     a0, b0, c0;
      bit     rnd, sat;
      longint y;
      bit     ovf;
   } vec_t;

   localparam int NV = 10;
   vec_t vt [NV];

   int cnt, lat;
   bit found;

   initial begin
      vt[0] = '{0, 100, 1, 3, 0, 0, 396, 0};
      vt[1] = '{0, -131072, -128, -2048, 0, 0, 276824064, 0};
      vt[2] = '{1, 24, 0, 1, 0, 0, 1, 0};
      vt[3] = '{1, 24, 0, 1, 1, 0, 2, 0};
      vt[4] = '{1, -24, 0, 1, 0, 0, -2, 0};
      vt[5] = '{1, -24, 0, 1, 1, 0, -1, 0};
      vt[6] = '{2, 131071, 0, 2047, 0, 1, 32767, 1};
      vt[7] = '{2, 131071, 0, 2047, 0, 0, -2047, 1};
      vt[8] = '{2, -131072, -128, 2047, 0, 1, -32768, 1};
      vt[9] = '{2, 100, 1, 3, 0, 0, 396, 0};

      ce = 1'b1; in_valid = 1'b0; rnd_en = 1'b0; sat_en = 1'b0; clr = 1'b0;
      a = '0; b = '0; c = '0;
      reset_model();

      // Reset state.
      #12;
      check_outputs();
      for (int k = 0; k < 3; k++) chk("reset_y", k, y_obs[k], 0);
      #1 rst_n = 1'b1;

      // Table vectors: one sample, result expected after exactly 5 cycles.
      for (int v = 0; v < NV; v++) begin
         a = {18'd0, 18'(vt[v].a0)};
         b = {8'd0, 8'(vt[v].b0)};
         c = {12'd0, 12'(vt[v].c0)};
         rnd_en = vt[v].rnd; sat_en = vt[v].sat; in_valid = 1'b1;
         tick();
         in_valid = 1'b0; a = '0; b = '0; c = '0;
         for (int j = 0; j < 4; j++) tick();
         chk("vec_valid", vt[v].dut, longint'(v_obs[vt[v].dut]), 1);
         chk("vec_y", vt[v].dut, y_obs[vt[v].dut], vt[v].y);
         chk("vec_ovf", vt[v].dut, longint'(o_obs[vt[v].dut]), longint'(vt[v].ovf));
         $display("[TB] vec %0d dut%0d y=%0d ovf=%0d", v, vt[v].dut, y_obs[vt[v].dut], o_obs[vt[v].dut]);
      end

      // Sticky held from earlier overflows; clr on a non-overflow output clears.
      chk("sticky_held", 2, longint'(s_obs[2]), 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("sticky_clr", 2, longint'(s_obs[2]), 0);

      // clr coincident with an overflowing output: set wins.
      a = {18'd0, 18'd131071}; b = '0; c = {12'd0, 12'd2047};
      rnd_en = 1'b0; sat_en = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) tick();
      chk("ovf_shown", 2, longint'(o_obs[2]), 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("sticky_set_wins", 2, longint'(s_obs[2]), 1);
      $display("[TB] clr/overflow coincidence sticky=%0d", s_obs[2]);

      // Back-to-back stream of 8 with a 3-cycle ce stall after the 4th.
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         rand_inputs(); in_valid = 1'b1;
         tick(); cnt += int'(v_obs[0]);
         if (i == 3) begin
            ce = 1'b0;
            for (int j = 0; j < 3; j++) begin
               rand_inputs(); tick(); cnt += int'(v_obs[0]);
            end
            ce = 1'b1;
         end
      end
      in_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick(); cnt += int'(v_obs[0]);
      end
      chk("stream_count", 0, longint'(cnt), 8);
      $display("[TB] stream of 8 with stall: %0d results", cnt);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); in_valid = 1'b1; tick();
      end
      #3 rst_n = 1'b0;
      reset_model();
      #1;
      check_outputs();
      for (int k = 0; k < 3; k++) chk("async_rst_y", k, y_obs[k], 0);
      in_valid = 1'b0;
      tick();
      #3 rst_n = 1'b1;
      rand_inputs(); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0; found = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (v_obs[0] && !found) begin
            found = 1'b1;
            lat = j + 1;
         end
      end
      chk("rst_latency", 0, longint'(lat), 5);
      $display("[TB] post-reset first sample latency=%0d", lat);

      // Randomised traffic: valid, ce, modes and clr all toggling.
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         in_valid = ($urandom_range(0, 9) < 7);
         ce       = ($urandom_range(0, 9) < 8);
         clr      = ($urandom_range(0, 19) == 0);
         tick();
      end
      ce = 1'b1; clr = 1'b0; in_valid = 1'b0;
      for (int j = 0; j < 6; j++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
